// File: rtl/lenbuf_ctrl_if.sv
// lenbuf_ctrl_if: code-length stream from lenbuf_ctrl to the Huffman table builder.
interface lenbuf_ctrl_if;
  logic       out_vld;
  logic       out_rdy;
  logic [3:0] out_len;
  logic [8:0] out_sym;
  logic       out_tbl;
  logic       out_last;
  modport master(output out_vld, out_len, out_sym, out_tbl, out_last, input out_rdy);
  modport slave(input out_vld, out_len, out_sym, out_tbl, out_last, output out_rdy);
endinterface

// File: rtl/lenbuf_ctrl.sv
// lenbuf_ctrl: fills the code-length buffer from the extractor, then streams lit/len and distance lengths.
// LENBUF_STAT_EN adds lit_nz/dst_nz nonzero-length counts and rejects an all-zero lit table.
module lenbuf_ctrl #(
  parameter int AW = 9,
  parameter int DW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [4:0]    hlit,
  input  logic [4:0]    hdist,
  output logic          ext_en,
  input  logic          winc,
  input  logic [AW-1:0] buff_addr,
  input  logic [DW-1:0] buff_data,
  input  logic          finish,
  output logic          mem_we,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  lenbuf_ctrl_if.master o,
  output logic          busy,
  output logic          done,
  output logic          err
`ifdef LENBUF_STAT_EN
  ,
  output logic [8:0]    lit_nz,
  output logic [5:0]    dst_nz
`endif
);
  typedef enum logic [2:0] {IDLE, FILL, RD, OUT, DONE, ERR} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] n_lit_q, n_lit_d, n_dst_q, n_dst_d, wr_cnt_q, wr_cnt_d, idx_q, idx_d;
  logic tbl_q, tbl_d, vld_q, vld_d, cap_q, cap_d, last_q, last_d, err_q, err_d, done_q, done_d;
  logic [3:0] len_q, len_d, len_c;
  logic [AW-1:0] total, n_tbl, wr_nxt;
  logic idle, bad, hs, lit_zero, unused_rdata;
  assign idle = state_q inside {IDLE, DONE, ERR};
  assign total = n_lit_q + n_dst_q;
  assign n_tbl = tbl_q ? n_dst_q : n_lit_q;
  assign ext_en = state_q == FILL;
  assign mem_re = state_q == RD;
  assign busy = !idle;
  assign bad = winc && (buff_addr >= total || buff_data > DW'(15));
  assign mem_we = ext_en && winc && !bad;
  assign mem_addr = ext_en ? buff_addr : mem_re ? idx_q + (tbl_q ? n_lit_q : '0) : '0;
  assign mem_wdata = ext_en ? buff_data : '0;
  assign wr_nxt = wr_cnt_q + AW'(mem_we);
  assign hs = vld_q && o.out_rdy;
  // RAM data is only guaranteed in the first OUT cycle; it is captured there and held after.
  assign len_c = cap_q ? mem_rdata[3:0] : len_q;
  assign unused_rdata = ^mem_rdata[DW-1:4];
  assign o.out_vld = vld_q;
  assign o.out_len = len_c;
  assign o.out_sym = 9'(idx_q);
  assign o.out_tbl = tbl_q;
  assign o.out_last = last_q;
  assign done = done_q;
  assign err = err_q;
  always_comb begin
    state_d = state_q;
    n_lit_d = n_lit_q;
    n_dst_d = n_dst_q;
    wr_cnt_d = wr_cnt_q;
    idx_d = idx_q;
    tbl_d = tbl_q;
    vld_d = vld_q;
    last_d = last_q;
    err_d = err_q;
    cap_d = 1'b0;
    done_d = 1'b0;
    len_d = len_c;
    if (start && idle) begin
      state_d = FILL;
      n_lit_d = AW'(257) + AW'(hlit);
      n_dst_d = AW'(hdist) + AW'(1);
      wr_cnt_d = '0;
      idx_d = '0;
      tbl_d = 1'b0;
      err_d = 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          wr_cnt_d = wr_nxt;
          state_d = bad ? ERR : finish ? (wr_nxt == total ? RD : ERR) : FILL;
        end
        RD: begin
          state_d = OUT;
          vld_d = 1'b1;
          cap_d = 1'b1;
          last_d = idx_q == n_tbl - AW'(1);
        end
        OUT: if (hs) begin
          vld_d = 1'b0;
          if (!last_q) begin
            idx_d = idx_q + AW'(1);
            state_d = RD;
          end else if (!tbl_q) begin
            tbl_d = 1'b1;
            idx_d = '0;
            state_d = lit_zero ? ERR : RD;
          end else begin
            done_d = 1'b1;
            state_d = DONE;
          end
        end
        default: ;
      endcase
    end
    if (state_d == ERR) err_d = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      n_lit_q <= '0;
      n_dst_q <= '0;
      wr_cnt_q <= '0;
      idx_q <= '0;
      tbl_q <= 1'b0;
      vld_q <= 1'b0;
      cap_q <= 1'b0;
      last_q <= 1'b0;
      err_q <= 1'b0;
      done_q <= 1'b0;
      len_q <= '0;
    end else begin
      state_q <= state_d;
      n_lit_q <= n_lit_d;
      n_dst_q <= n_dst_d;
      wr_cnt_q <= wr_cnt_d;
      idx_q <= idx_d;
      tbl_q <= tbl_d;
      vld_q <= vld_d;
      cap_q <= cap_d;
      last_q <= last_d;
      err_q <= err_d;
      done_q <= done_d;
      len_q <= len_d;
    end
`ifdef LENBUF_STAT_EN
  logic [8:0] lit_nz_q, lit_nz_d;
  logic [5:0] dst_nz_q, dst_nz_d;
  always_comb begin
    lit_nz_d = lit_nz_q;
    dst_nz_d = dst_nz_q;
    if (start && idle) begin
      lit_nz_d = '0;
      dst_nz_d = '0;
    end else if (state_q == OUT && hs && len_c != 4'd0) begin
      lit_nz_d = tbl_q ? lit_nz_q : lit_nz_q + 9'd1;
      dst_nz_d = tbl_q ? dst_nz_q + 6'd1 : dst_nz_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lit_nz_q <= '0;
      dst_nz_q <= '0;
    end else begin
      lit_nz_q <= lit_nz_d;
      dst_nz_q <= dst_nz_d;
    end
  assign lit_nz = lit_nz_q;
  assign dst_nz = dst_nz_q;
  assign lit_zero = lit_nz_d == '0;
`else
  assign lit_zero = 1'b0;
`endif
endmodule

// File: tb/tb_lenbuf_ctrl.sv
// tb_lenbuf_ctrl: directed bench for lenbuf_ctrl with a synchronous-read RAM model.
module tb_lenbuf_ctrl;
  logic clk, rst_n, start, winc, finish;
  logic [4:0] hlit, hdist, buff_data, mem_wdata, mem_rdata;
  logic [8:0] buff_addr, mem_addr;
  logic ext_en, mem_we, mem_re, busy, done, err;
  logic [4:0] ram [512];
  int n_chk = 0, n_err = 0;
  lenbuf_ctrl_if bus();
  lenbuf_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hlit(hlit), .hdist(hdist), .ext_en(ext_en),
    .winc(winc), .buff_addr(buff_addr), .buff_data(buff_data), .finish(finish),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .o(bus), .busy(busy), .done(done), .err(err)
`ifdef LENBUF_STAT_EN
    , .lit_nz(), .dst_nz()
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic fill(input int hl, input int hd, input int nw, input bit same);
    @(negedge clk);
    hlit = 5'(hl);
    hdist = 5'(hd);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("fill_ext_en", int'(ext_en), 1);
    for (int a = 0; a < nw; a++) begin
      winc = 1'b1;
      buff_addr = 9'(a);
      buff_data = 5'(a % 16);
      finish = same && a == nw - 1;
      #1;
      if (a == 0) chk("fill_we", int'(mem_we), 1);
      @(negedge clk);
    end
    winc = 1'b0;
    finish = !same;
    if (!same) @(negedge clk);
    finish = 1'b0;
  endtask
  task automatic drain(input int nl, input int nd, input bit tog);
    int k = 0, first = -1, lastc = 0, ndone = 0, expv;
    bit stall = 1'b0, dchk = 1'b0;
    logic [14:0] cur, pv = '0;
    for (int c = 0; c < 3000 && ndone == 0; c++) begin
      cur = {bus.out_tbl, bus.out_last, bus.out_sym, bus.out_len};
      if (stall) chk("hold", int'({bus.out_vld, cur}), int'({1'b1, pv}));
      if (mem_re && bus.out_tbl && bus.out_sym == 9'd0 && !dchk) begin
        dchk = 1'b1;
        chk("dst0_addr", int'(mem_addr), nl);
      end
      if (done) ndone++;
      bus.out_rdy = tog ? (c % 2 == 1) : 1'b1;
      if (bus.out_vld && bus.out_rdy) begin
        expv = ((k >= nl ? 1 : 0) << 14) | ((k == nl - 1 || k == nl + nd - 1 ? 1 : 0) << 13)
             | ((k >= nl ? k - nl : k) << 4) | (k % 16);
        chk($sformatf("len_%0d", k), int'(cur), expv);
        if (first < 0) first = c;
        lastc = c;
        k++;
      end
      stall = bus.out_vld && !bus.out_rdy;
      pv = cur;
      @(negedge clk);
    end
    bus.out_rdy = 1'b1;
    chk("done_seen", ndone, 1);
    chk("hs_count", k, nl + nd);
    if (!tog) chk("rate", lastc - first, 2 * (nl + nd - 1));
    chk("done_pulse", int'(done), 0);
    chk("busy_end", int'(busy), 0);
    chk("err_end", int'(err), 0);
  endtask
  initial begin
    int seen;
    rst_n = 1'b0;
    {start, winc, finish} = '0;
    hlit = '0;
    hdist = '0;
    buff_addr = '0;
    buff_data = '0;
    bus.out_rdy = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_outs", int'({ext_en, mem_we, mem_re, busy, done, err, bus.out_vld}), 0);
    chk("rst_bus", int'({mem_addr, mem_wdata, bus.out_len, bus.out_sym, bus.out_tbl, bus.out_last}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    // nominal: 257 lit + 1 dst
    fill(0, 0, 258, 1'b0);
    chk("nom_rd", int'(mem_re), 1);
    chk("nom_rd_addr", int'(mem_addr), 0);
    drain(257, 1, 1'b0);
    // maximum sizes
    fill(31, 31, 320, 1'b0);
    chk("max_rd", int'(mem_re), 1);
    drain(288, 32, 1'b0);
    // simultaneous last write and finish, with toggling backpressure
    fill(0, 0, 258, 1'b1);
    chk("simul_rd", int'(mem_re), 1);
    chk("simul_ram", int'(ram[257]), 1);
    drain(257, 1, 1'b1);
    // one write short
    fill(0, 0, 257, 1'b0);
    chk("cnt_err", int'(err), 1);
    chk("cnt_busy", int'(busy), 0);
    winc = 1'b1;
    #1 chk("err_winc_we", int'(mem_we), 0);
    winc = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.out_vld) seen++;
    end
    chk("err_novld", seen, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_err", int'(err), 0);
    chk("restart_fill", int'(ext_en), 1);
    winc = 1'b1;
    buff_addr = 9'd300;
    buff_data = 5'd3;
    #1 chk("range_addr_we", int'(mem_we), 0);
    @(negedge clk);
    winc = 1'b0;
    chk("range_addr_err", int'(err), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    winc = 1'b1;
    buff_addr = 9'd5;
    buff_data = 5'd16;
    #1 chk("range_data_we", int'(mem_we), 0);
    @(negedge clk);
    winc = 1'b0;
    chk("range_data_err", int'(err), 1);
    // reset in the middle of the drain
    fill(0, 0, 258, 1'b0);
    seen = 0;
    for (int c = 0; c < 10 && !bus.out_vld; c++) @(negedge clk);
    chk("pre_rst_vld", int'(bus.out_vld), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", int'(bus.out_vld), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_re", int'(mem_re), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
